// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock with frame snapshot and leading-zero blanking.
// Optional field blinking is compiled in when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLINK_DIV = 128
) (
   input  logic       CP,
   input  logic       reset,
   input  logic [7:0] hour,
   input  logic [7:0] minute,
   input  logic [7:0] second,
   input  logic       lzb,
   input  logic [1:0] set_sel,
   output logic [5:0] AN,
   output logic [6:0] SEG,
   output logic       DP
);

   localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned SLOT_W = 3;
   localparam int unsigned SNAP_W = 24;
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(5);

   logic [CNT_W-1:0]  pre_cnt;
   logic [SLOT_W-1:0] slot;
   logic [SNAP_W-1:0] snap;

   logic              tick;
   logic [SLOT_W-1:0] slot_nxt;
   logic [3:0]        nib;
   logic              blank;
   logic [5:0]        an_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

`ifdef SEG7_SCAN_BLINK_EN
   localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] blk_cnt;
   logic             phase;

   // Blink phase toggles once every BLINK_DIV scan ticks.
   always_ff @(posedge CP or posedge reset) begin
      if (reset) begin
         blk_cnt <= '0;
         phase   <= 1'b0;
      end else if (tick) begin
         if (blk_cnt == BLK_MAX) begin
            blk_cnt <= '0;
            phase   <= ~phase;
         end else begin
            blk_cnt <= blk_cnt + BLK_W'(1);
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{set_sel, 32'(BLINK_DIV)};
`endif

   // Second units always come from the live input, so the snapshot copy of them is never read.
   logic unused_snap;
   assign unused_snap = ^snap[3:0];

   // Next-slot selection, digit source and blanking, all evaluated for the slot entered at the tick.
   always_comb begin
      tick     = (pre_cnt == CNT_MAX);
      slot_nxt = (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
      nib      = 4'd0;
      case (slot_nxt)
         3'd0:    nib = second[3:0];
         3'd1:    nib = snap[7:4];
         3'd2:    nib = snap[11:8];
         3'd3:    nib = snap[15:12];
         3'd4:    nib = snap[19:16];
         default: nib = snap[23:20];
      endcase
      blank = lzb && (slot_nxt == SLOT_LAST) && (snap[23:20] == 4'd0);
`ifdef SEG7_SCAN_BLINK_EN
      if (phase && (set_sel != 2'd0) && (slot_nxt[2:1] == (set_sel - 2'd1)))
         blank = 1'b1;
`endif
      an_nxt = blank ? 6'h3F : ~(6'd1 << slot_nxt);
   end

   always_ff @(posedge CP or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
         slot    <= SLOT_LAST;
         snap    <= '0;
         AN      <= 6'h3F;
         SEG     <= 7'h7F;
         DP      <= 1'b1;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
         if (tick) begin
            slot <= slot_nxt;
            // Frame start: freeze the whole time value so no frame mixes two readings.
            if (slot_nxt == '0)
               snap <= {hour, minute, second};
            AN  <= an_nxt;
            SEG <= seg_decode(nib);
            DP  <= ~((slot_nxt == SLOT_W'(2)) || (slot_nxt == SLOT_W'(4)));
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (SCAN_DIV=4, BLINK_DIV=2): scan order, snapshot, blanking, dash decode, reset.
module tb_seg7_scan;

   localparam int unsigned SCAN_DIV  = 4;
   localparam int unsigned BLINK_DIV = 2;

   logic       CP;
   logic       reset;
   logic [7:0] hour;
   logic [7:0] minute;
   logic [7:0] second;
   logic       lzb;
   logic [1:0] set_sel;
   logic [5:0] AN;
   logic [6:0] SEG;
   logic       DP;

   int         checks;
   int         errors;
   int         ticks;
   logic [5:0] prev_an;

   seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .CP(CP), .reset(reset), .hour(hour), .minute(minute), .second(second),
      .lzb(lzb), .set_sel(set_sel), .AN(AN), .SEG(SEG), .DP(DP)
   );

   initial CP = 1'b0;
   always #5 CP = ~CP;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Checks outputs hold until the tick, then the new slot's AN/SEG/DP.
   task automatic slot_chk(input string tag, input int slot,
                           input logic [5:0] an_e, input logic [6:0] seg_e, input logic dp_e);
      logic [5:0] an_x;
      string      t;
      an_x = an_e;
      t = $sformatf("%s_s%0d", tag, slot);
      repeat (SCAN_DIV - 1) @(posedge CP);
      #1;
      check({t, "_hold"}, 16'(AN), 16'(prev_an));
      @(posedge CP);
      #1;
      ticks++;
`ifdef SEG7_SCAN_BLINK_EN
      if ((((ticks - 1) / BLINK_DIV) % 2 == 1) && (set_sel != 2'd0) && ((slot / 2) == int'(set_sel) - 1))
         an_x = 6'h3F;
`endif
      check({t, "_an"}, 16'(AN), 16'(an_x));
      if (an_x != 6'h3F)
         check({t, "_seg"}, 16'(SEG), 16'(seg_e));
      check({t, "_dp"}, 16'(DP), 16'(dp_e));
      prev_an = an_x;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      ticks   = 0;
      prev_an = 6'h3F;
      reset   = 1'b0;
      hour    = 8'h12;
      minute  = 8'h34;
      second  = 8'h56;
      lzb     = 1'b0;
      set_sel = 2'd0;
      #1 reset = 1'b1;
      repeat (3) @(posedge CP);
      #1;
      check("rst_an", 16'(AN), 16'h003F);
      check("rst_seg", 16'(SEG), 16'h007F);
      check("rst_dp", 16'(DP), 16'h0001);
      @(negedge CP) reset = 1'b0;

      // Frame 1: 12:34:56
      slot_chk("f1", 0, 6'b111110, 7'b0000010, 1'b1);
      slot_chk("f1", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f1", 2, 6'b111011, 7'b0011001, 1'b0);
      slot_chk("f1", 3, 6'b110111, 7'b0110000, 1'b1);
      slot_chk("f1", 4, 6'b101111, 7'b0100100, 1'b0);
      slot_chk("f1", 5, 6'b011111, 7'b1111001, 1'b1);

      // Frame 2: seconds change mid-frame must not disturb the rest of the frame
      set_sel = 2'd2;
      slot_chk("f2", 0, 6'b111110, 7'b0000010, 1'b1);
      second = 8'h57;
      slot_chk("f2", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f2", 2, 6'b111011, 7'b0011001, 1'b0);
      slot_chk("f2", 3, 6'b110111, 7'b0110000, 1'b1);
      slot_chk("f2", 4, 6'b101111, 7'b0100100, 1'b0);
      slot_chk("f2", 5, 6'b011111, 7'b1111001, 1'b1);
      hour   = 8'h05;
      minute = 8'hA3;
      lzb    = 1'b1;

      // Frame 3: 05:A3:57 with blanking on
      slot_chk("f3", 0, 6'b111110, 7'b1111000, 1'b1);
      slot_chk("f3", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f3", 2, 6'b111011, 7'b0110000, 1'b0);
      slot_chk("f3", 3, 6'b110111, 7'b0111111, 1'b1);
      slot_chk("f3", 4, 6'b101111, 7'b0010010, 1'b0);
      slot_chk("f3", 5, 6'b111111, 7'b1000000, 1'b1);
      minute = 8'h34;
      lzb    = 1'b0;

      // Frame 4: 05:34:57 with blanking off
      slot_chk("f4", 0, 6'b111110, 7'b1111000, 1'b1);
      slot_chk("f4", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f4", 2, 6'b111011, 7'b0011001, 1'b0);
      slot_chk("f4", 3, 6'b110111, 7'b0110000, 1'b1);
      slot_chk("f4", 4, 6'b101111, 7'b0010010, 1'b0);
      slot_chk("f4", 5, 6'b011111, 7'b1000000, 1'b1);

      // Frame 5: reset during slot 3 acts without a clock edge
      slot_chk("f5", 0, 6'b111110, 7'b1111000, 1'b1);
      slot_chk("f5", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f5", 2, 6'b111011, 7'b0011001, 1'b0);
      slot_chk("f5", 3, 6'b110111, 7'b0110000, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_an", 16'(AN), 16'h003F);
      check("mid_rst_seg", 16'(SEG), 16'h007F);
      check("mid_rst_dp", 16'(DP), 16'h0001);
      repeat (3) @(posedge CP);
      #1;
      check("mid_rst_hold_an", 16'(AN), 16'h003F);
      @(negedge CP) reset = 1'b0;
      prev_an = 6'h3F;
      ticks   = 0;

      // Restart begins at slot 0
      slot_chk("f6", 0, 6'b111110, 7'b1111000, 1'b1);
      slot_chk("f6", 1, 6'b111101, 7'b0010010, 1'b1);
      slot_chk("f6", 2, 6'b111011, 7'b0011001, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, means CP cycles per digit slot; legal range is 2..2^20.
REQ-002 Parameter BLINK_DIV, default 128, means scan ticks per blink half-period; legal range is 2..2^12.
REQ-003 Port CP, input, 1 bit, is the single system clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit, is an asynchronous active-high reset.
REQ-005 Port hour, input, 8 bits, is packed BCD hours: [7:4] tens, [3:0] units.
REQ-006 Port minute, input, 8 bits, is packed BCD minutes from the upstream 60-counter.
REQ-007 Port second, input, 8 bits, is packed BCD seconds from the upstream 60-counter.
REQ-008 Port lzb, input, 1 bit, enables leading-zero blanking of the hour-tens digit.
REQ-009 Port set_sel, input, 2 bits, selects the blinking field: 0 none, 1 seconds, 2 minutes, 3 hours.
REQ-010 Port AN, output, 6 bits, holds registered active-low digit enables; bit i drives digit slot i.
REQ-011 Port SEG, output, 7 bits, holds registered active-low segments {g,f,e,d,c,b,a}.
REQ-012 Port DP, output, 1 bit, is the registered active-low decimal point.

Function
REQ-013 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; "tick" is the cycle in which it equals SCAN_DIV-1.
REQ-014 The slot index SHALL advance on each tick: 0,1,2,3,4,5, then wrap to 0.
REQ-015 Slot mapping SHALL be: 0 second[3:0], 1 second[7:4], 2 minute[3:0], 3 minute[7:4], 4 hour[3:0], 5 hour[7:4].
REQ-016 On the tick that advances the index to 0, a 24-bit snapshot SHALL load {hour,minute,second}; slots 1-5 decode from the snapshot and slot 0 decodes from the live inputs, which equal the loaded values. No frame mixes two input values.
REQ-017 AN, SEG and DP SHALL update only on the tick edge and hold between ticks.
REQ-018 On that edge, exactly one AN bit (the new slot) SHALL go low unless the slot is blanked; a blanked slot drives all AN bits high.
REQ-019 Decode SHALL produce: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 Any nibble greater than 9 SHALL decode as a dash, 0111111.
REQ-021 DP SHALL be 0 in slots 2 and 4 and 1 in all other slots.
REQ-022 If lzb=1 and the hour-tens nibble is 0, slot 5 SHALL be blanked.
REQ-023 Inputs SHALL have no effect except through the snapshot, slot-0 decode, lzb and set_sel sampled at the tick.

Reset
REQ-024 Asserting reset SHALL immediately set AN=111111, SEG=1111111, DP=1, prescaler=0, index=5, snapshot=0 and blink phase=0.
REQ-025 After reset is released, the first tick SHALL move the index to 0 and load the snapshot (per REQ-016).
REQ-026 A reset asserted mid-frame SHALL abort the frame with no partial output held.

Configuration
REQ-027 With macro SEG7_SCAN_BLINK_EN defined, a blink counter SHALL count ticks and toggle the blink phase every BLINK_DIV ticks.
REQ-028 With SEG7_SCAN_BLINK_EN defined, while phase=1 both slots of the field selected by set_sel SHALL be blanked; set_sel=0 blanks nothing.
REQ-029 With SEG7_SCAN_BLINK_EN undefined, set_sel SHALL be ignored, no blink counter SHALL be instantiated, and BLINK_DIV SHALL be unused.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-030 Hold reset, then release with inputs 12:34:56 → first tick gives AN=111110, SEG=0000010 (6), DP=1; next ticks give 5, 4 (DP=0), 3, 2 (DP=0), 1; then the sequence wraps.
REQ-031 Change second from 56 to 57 mid-frame → the remaining slots still show 5 and 6; the new value appears only from the next slot 0.
REQ-032 Set hour=05 with lzb=1 → slot 5 gives AN=111111; with lzb=0 it gives AN=011111 and SEG=1000000.
REQ-033 Set minute=8'hA3 → slot 3 gives SEG=0111111.
REQ-034 With SEG7_SCAN_BLINK_EN defined and set_sel=2 → slots 2 and 3 alternate blanked and visible every 2 ticks; with the macro undefined they are always visible.
REQ-035 Assert reset during slot 3 → AN=111111 in the same cycle without waiting for CP; after release the first tick restarts at slot 0.
